// File: rtl/ssd_mux_driver.sv
// ---------------------------------------------------------------------------
// ssd_mux_driver
//   Drives a 2-digit PmodSSD from one byte. The two digits are time-multiplexed
//   (right digit = low nibble, left digit = high nibble), with a blanking dead
//   time around every digit switch to suppress ghosting. The input byte is
//   sampled once per frame, on the edge entering the low-digit ON phase, so both
//   digits always show the same value.
//
// Parameters
//   DIGIT_TICKS : clk cycles each digit is lit (>= 1)
//   DEAD_TICKS  : clk cycles segments are blanked around each switch (>= 1)
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   value      : byte to display (may change on any cycle)
//   seg        : {g,f,e,d,c,b,a}, active-high, registered
//   digit_sel  : 0 = right (low nibble), 1 = left (high nibble), registered
//   frame_tick : 1-cycle pulse on the first LO_ON cycle (sample cycle), registered
//
// Configuration macro
//   SSD_BLANK_LEADING_ZERO_EN : when defined, the left digit is dark whenever
//                               the high nibble is zero.
// ---------------------------------------------------------------------------
module ssd_mux_driver #(
  parameter int DIGIT_TICKS = 100_000,
  parameter int DEAD_TICKS  = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       digit_sel,
  output logic       frame_tick
);

  localparam int MAX_TICKS = (DIGIT_TICKS > DEAD_TICKS) ? DIGIT_TICKS : DEAD_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_TICKS - 1);

  typedef enum logic [1:0] {
    DEAD_TO_LO = 2'd0,
    LO_ON      = 2'd1,
    DEAD_TO_HI = 2'd2,
    HI_ON      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [6:0]       seg_q, seg_d;
  logic             sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             last;

  function automatic logic [6:0] hex_dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEAD_TO_LO;
      cnt_q    <= '0;
      shadow_q <= '0;
      seg_q    <= '0;
      sel_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    seg_d    = '0;
    sel_d    = 1'b0;

    last = ((state_q == LO_ON) || (state_q == HI_ON)) ? (cnt_q == DIGIT_LAST)
                                                       : (cnt_q == DEAD_LAST);

    if (last) begin
      cnt_d = '0;
      case (state_q)
        DEAD_TO_LO: state_d = LO_ON;
        LO_ON:      state_d = DEAD_TO_HI;
        DEAD_TO_HI: state_d = HI_ON;
        default:    state_d = DEAD_TO_LO;
      endcase
    end

    // Sample on the edge entering LO_ON; the registered outputs below are
    // decoded from shadow_d so the first lit cycle already shows the new byte.
    if (last && (state_q == DEAD_TO_LO)) begin
      shadow_d = value;
      tick_d   = 1'b1;
    end

    // Outputs are derived from the next state so they change exactly on the
    // state-entry edge: digit_sel only moves when entering a dead state.
    case (state_d)
      LO_ON: begin
        seg_d = hex_dec(shadow_d[3:0]);
      end
      DEAD_TO_HI: begin
        sel_d = 1'b1;
      end
      HI_ON: begin
        sel_d = 1'b1;
`ifdef SSD_BLANK_LEADING_ZERO_EN
        seg_d = (shadow_d[7:4] == 4'h0) ? 7'h00 : hex_dec(shadow_d[7:4]);
`else
        seg_d = hex_dec(shadow_d[7:4]);
`endif
      end
      default: begin
        seg_d = '0;
      end
    endcase
  end

  assign seg        = seg_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_mux_driver
//   Self-checking bench for ssd_mux_driver with DIGIT_TICKS=4, DEAD_TICKS=2.
//   A frame-position model pushes the expected {frame_tick, digit_sel, seg}
//   for every cycle into a queue as stimulus is driven; each scenario task
//   pops and compares after the clock edge.
// ---------------------------------------------------------------------------
module tb_ssd_mux_driver;

  localparam int DIGIT = 4;
  localparam int DEAD  = 2;
  localparam int FRAME = 2 * (DIGIT + DEAD);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'h00;
  logic [6:0] seg;
  logic       digit_sel;
  logic       frame_tick;

  always #5 clk = ~clk;

  ssd_mux_driver #(.DIGIT_TICKS(DIGIT), .DEAD_TICKS(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb_q[$];
  int         next_phase = 1;
  logic [7:0] snap = 8'h00;
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected outputs of the cycle that begins at the next posedge, given the
  // value present at that edge. Phase counts cycles from the start of a frame.
  task automatic sb_push(input logic [7:0] v);
    int p;
    logic [6:0] s;
    logic sel, ft;
    p = next_phase;
    s = 7'h00; sel = 1'b0; ft = 1'b0;
    if (p == DEAD) begin
      snap = v;
      ft   = 1'b1;
    end
    if (p >= DEAD && p < DEAD + DIGIT) s = dec_tab[snap[3:0]];
    if (p >= DEAD + DIGIT) sel = 1'b1;
    if (p >= 2 * DEAD + DIGIT) begin
`ifdef SSD_BLANK_LEADING_ZERO_EN
      s = (snap[7:4] == 4'h0) ? 7'h00 : dec_tab[snap[7:4]];
`else
      s = dec_tab[snap[7:4]];
`endif
    end
    sb_q.push_back({ft, sel, s});
    next_phase = (p + 1) % FRAME;
  endtask

  task automatic cycle(input logic [7:0] v);
    value = v;
    sb_push(v);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    next_phase = 1;
    snap = 8'h00;
    sb_q.delete();
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    int ft_at[$];
    value = 8'h3A;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if ({frame_tick, digit_sel, seg} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_hold: got ft=%0b sel=%0b seg=%h want 0/0/00", frame_tick, digit_sel, seg);
    end
    release_reset();
    n_tests++;
    if ({frame_tick, digit_sel, seg} !== 9'h000) begin
      n_fail++;
      $display("FAIL cycle0: got ft=%0b sel=%0b seg=%h want 0/0/00", frame_tick, digit_sel, seg);
    end
    for (int k = 1; k < 2 * FRAME + 1; k++) begin
      cycle(8'h3A);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL basic_3A cyc%0d: got %h want %h", k, {frame_tick, digit_sel, seg}, exp);
      end
      if (frame_tick) ft_at.push_back(k);
      if (k == 2 || k == 5) begin
        n_tests++;
        if (seg !== 7'h77 || digit_sel !== 1'b0) begin
          n_fail++;
          $display("FAIL lo_digit_A cyc%0d: got seg=%h sel=%0b want 77/0", k, seg, digit_sel);
        end
      end
      if (k == 8 || k == 11) begin
        n_tests++;
        if (seg !== 7'h4F || digit_sel !== 1'b1) begin
          n_fail++;
          $display("FAIL hi_digit_3 cyc%0d: got seg=%h sel=%0b want 4F/1", k, seg, digit_sel);
        end
      end
    end
    n_tests++;
    if (ft_at.size() !== 2 || ft_at[0] !== 2 || ft_at[1] - ft_at[0] !== FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d ticks first=%0d want 2 ticks first=2 period=%0d",
               ft_at.size(), (ft_at.size() > 0) ? ft_at[0] : -1, FRAME);
    end
  endtask

  task automatic test_stale_value();
    logic [8:0] exp;
    while (next_phase != DEAD) begin
      cycle(8'h12);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL stale_align: got %h want %h", {frame_tick, digit_sel, seg}, exp);
      end
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle((k == 0) ? 8'h12 : 8'hFF);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL stale k%0d: got %h want %h", k, {frame_tick, digit_sel, seg}, exp);
      end
      if (k == 0 || k == DIGIT + DEAD || k == FRAME || k == FRAME + DIGIT + DEAD) begin
        n_tests++;
        if (seg !== ((k == 0) ? 7'h5B : (k == DIGIT + DEAD) ? 7'h06 : 7'h71)) begin
          n_fail++;
          $display("FAIL stale_digit k%0d: got seg=%h", k, seg);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [8:0] exp;
    int idx, ticks;
    logic [7:0] v;
    while (next_phase != DEAD) begin
      cycle(8'h00);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL sweep_align: got %h want %h", {frame_tick, digit_sel, seg}, exp);
      end
    end
    idx = 0;
    ticks = 0;
    for (int k = 0; k < 256 * FRAME; k++) begin
      if (next_phase == DEAD) begin
        v = idx[7:0];
        idx++;
      end else begin
        v = 8'($urandom);
      end
      cycle(v);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL sweep val=%h: got %h want %h", snap, {frame_tick, digit_sel, seg}, exp);
      end
      if (frame_tick) ticks++;
    end
    n_tests++;
    if (ticks !== 256) begin
      n_fail++;
      $display("FAIL sweep_tick_count: got %0d want 256", ticks);
    end
  endtask

  task automatic test_dead_time();
    logic [8:0] exp;
    logic prev_sel;
    int switches;
    prev_sel = digit_sel;
    switches = 0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      cycle(8'($urandom) | 8'h11);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL dead_model k%0d: got %h want %h", k, {frame_tick, digit_sel, seg}, exp);
      end
      if (digit_sel !== prev_sel) begin
        switches++;
        n_tests++;
        if (seg !== 7'h00) begin
          n_fail++;
          $display("FAIL dead_blank k%0d: got seg=%h want 00 at digit switch", k, seg);
        end
      end
      prev_sel = digit_sel;
    end
    n_tests++;
    if (switches !== 8) begin
      n_fail++;
      $display("FAIL dead_switch_count: got %0d want 8", switches);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    int found;
    while (next_phase != 2 * DEAD + DIGIT + 2) begin
      cycle(8'h88);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL rstmid_align: got %h want %h", {frame_tick, digit_sel, seg}, exp);
      end
    end
    n_tests++;
    if (seg !== 7'h7F || digit_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got seg=%h sel=%0b want 7F/1", seg, digit_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({frame_tick, digit_sel, seg} !== 9'h000) begin
      n_fail++;
      $display("FAIL rstmid_async: got ft=%0b sel=%0b seg=%h want 0/0/00", frame_tick, digit_sel, seg);
    end
    @(posedge clk);
    @(posedge clk);
    release_reset();
    found = -1;
    for (int k = 1; k <= 10; k++) begin
      cycle(8'h88);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL rstmid_restart cyc%0d: got %h want %h", k, {frame_tick, digit_sel, seg}, exp);
      end
      if (frame_tick && found < 0) found = k;
    end
    n_tests++;
    if (found !== DEAD) begin
      n_fail++;
      $display("FAIL rstmid_first_tick: got cycle %0d want %0d", found, DEAD);
    end
  endtask

  task automatic test_leading_zero();
    logic [8:0] exp;
    logic [6:0] hi_want;
`ifdef SSD_BLANK_LEADING_ZERO_EN
    hi_want = 7'h00;
`else
    hi_want = 7'h3F;
`endif
    while (next_phase != DEAD) begin
      cycle(8'h05);
      void'(sb_q.pop_front());
    end
    for (int k = 0; k < FRAME; k++) begin
      cycle(8'h05);
      exp = sb_q.pop_front();
      n_tests++;
      if ({frame_tick, digit_sel, seg} !== exp) begin
        n_fail++;
        $display("FAIL lz_model k%0d: got %h want %h", k, {frame_tick, digit_sel, seg}, exp);
      end
      if (k == 1) begin
        n_tests++;
        if (seg !== 7'h6D) begin
          n_fail++;
          $display("FAIL lz_lo: got seg=%h want 6D", seg);
        end
      end
      if (k == DIGIT + DEAD + 1) begin
        n_tests++;
        if (seg !== hi_want || digit_sel !== 1'b1) begin
          n_fail++;
          $display("FAIL lz_hi: got seg=%h sel=%0b want %h/1", seg, digit_sel, hi_want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stale_value();
    test_sweep();
    test_dead_time();
    test_reset_mid();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
